// File: rtl/serializer_arbiter.sv
// Round-robin arbiter that shares one serializer (start/busy/data handshake) among
// NUM_REQ byte producers, reporting per-requester grant and done pulses.
module serializer_arbiter #(
    parameter  int NUM_REQ    = 4,
    parameter  int DATA_WIDTH = 8,
    parameter  int START_WAIT = 4,
    localparam int OWNER_W    = $clog2(NUM_REQ)
) (
    input  logic                          i_clock,
    input  logic                          i_reset,
    input  logic [NUM_REQ-1:0]            i_req,
    input  logic [NUM_REQ*DATA_WIDTH-1:0] i_req_data,
    output logic [NUM_REQ-1:0]            o_grant,
    output logic [NUM_REQ-1:0]            o_done,
    output logic                          o_error,
    output logic                          o_ser_start,
    output logic [DATA_WIDTH-1:0]         o_ser_data,
    input  logic                          i_ser_busy,
    output logic                          o_active,
    output logic [OWNER_W-1:0]            o_owner
);

    localparam int CNT_W = $clog2(START_WAIT + 1);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_START = 2'd1,
        S_WAITB = 2'd2,
        S_SHIFT = 2'd3
    } state_t;

    state_t                  r_state;
    state_t                  w_next_state;
    logic [OWNER_W-1:0]      r_rr;
    logic [OWNER_W-1:0]      r_owner;
    logic [DATA_WIDTH-1:0]   r_ser_data;
    logic [CNT_W-1:0]        r_wait_cnt;
    logic [OWNER_W:0]        w_pick;
    logic                    w_pick_valid;
    logic [OWNER_W-1:0]      w_pick_idx;
    logic                    w_wait_expired;

    // Returns {valid, index} of the first set request at or above ptr, wrapping.
    // Scanning from the far end lets the lowest offset overwrite the result last.
    function automatic logic [OWNER_W:0] rr_pick(input logic [NUM_REQ-1:0] req,
                                                 input logic [OWNER_W-1:0] ptr);
        logic [OWNER_W:0]   result;
        logic [OWNER_W-1:0] idx;
        int                 j;
        result = '0;
        for (int i = NUM_REQ - 1; i >= 0; i--) begin
            j = int'(ptr) + i;
            if (j >= NUM_REQ) begin
                j = j - NUM_REQ;
            end
            idx = OWNER_W'(j);
            if (req[idx]) begin
                result = {1'b1, idx};
            end
        end
        return result;
    endfunction

    assign w_pick         = rr_pick(i_req, r_rr);
    assign w_pick_valid   = w_pick[OWNER_W];
    assign w_pick_idx     = w_pick[OWNER_W-1:0];
    assign w_wait_expired = (r_wait_cnt == CNT_W'(START_WAIT));

    always_ff @(posedge i_clock or posedge i_reset) begin
        if (i_reset) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    // Owner and byte are captured on the selection edge only, so later changes
    // to the requester's data never reach the serializer mid-transfer.
    always_ff @(posedge i_clock or posedge i_reset) begin
        if (i_reset) begin
            r_owner    <= '0;
            r_ser_data <= '0;
        end else if (r_state == S_IDLE && w_pick_valid) begin
            r_owner    <= w_pick_idx;
            r_ser_data <= i_req_data[w_pick_idx*DATA_WIDTH +: DATA_WIDTH];
        end
    end

    always_ff @(posedge i_clock or posedge i_reset) begin
        if (i_reset) begin
            r_rr <= '0;
        end else if (r_state == S_START) begin
            r_rr <= (r_owner == OWNER_W'(NUM_REQ - 1)) ? '0 : r_owner + 1'b1;
        end
    end

    always_ff @(posedge i_clock or posedge i_reset) begin
        if (i_reset) begin
            r_wait_cnt <= '0;
        end else if (r_state == S_START) begin
            r_wait_cnt <= '0;
        end else if (r_state == S_WAITB && !i_ser_busy && !w_wait_expired) begin
            r_wait_cnt <= r_wait_cnt + 1'b1;
        end
    end

    always_comb begin
        w_next_state = r_state;
        case (r_state)
            S_IDLE: begin
                if (w_pick_valid) begin
                    w_next_state = S_START;
                end
            end
            S_START: begin
                w_next_state = S_WAITB;
            end
            S_WAITB: begin
                if (i_ser_busy) begin
                    w_next_state = S_SHIFT;
                end else if (w_wait_expired) begin
                    w_next_state = S_IDLE;
                end
            end
            S_SHIFT: begin
                if (!i_ser_busy) begin
                    w_next_state = S_IDLE;
                end
            end
            default: begin
                w_next_state = S_IDLE;
            end
        endcase
    end

    always_comb begin
        o_grant     = '0;
        o_done      = '0;
        o_error     = 1'b0;
        o_ser_start = 1'b0;
        o_active    = (r_state != S_IDLE);
        case (r_state)
            S_START: begin
                o_ser_start      = 1'b1;
                o_grant[r_owner] = 1'b1;
            end
            S_WAITB: begin
                o_error = !i_ser_busy && w_wait_expired;
            end
            S_SHIFT: begin
                o_done[r_owner] = !i_ser_busy;
            end
            default: begin
            end
        endcase
    end

    assign o_ser_data = r_ser_data;
    assign o_owner    = r_owner;

`ifndef SYNTHESIS
    a_pulse_excl: assert property (@(posedge i_clock) disable iff (i_reset)
        $onehot0({|o_grant, |o_done, o_error}));
    a_grant_onehot: assert property (@(posedge i_clock) disable iff (i_reset)
        $onehot0(o_grant));
    a_done_onehot: assert property (@(posedge i_clock) disable iff (i_reset)
        $onehot0(o_done));
    a_owner_hold: assert property (@(posedge i_clock) disable iff (i_reset)
        (r_state == S_IDLE && !w_pick_valid) |=> $stable(o_owner));
`endif

endmodule

// File: tb/tb_serializer_arbiter.sv
// Directed bench for serializer_arbiter with a simple serializer model:
// busy rises one cycle after ser_start and stays high for 8 cycles.
module tb_serializer_arbiter;

    localparam int NUM_REQ    = 4;
    localparam int DATA_WIDTH = 8;
    localparam int START_WAIT = 4;

    logic                          clk;
    logic                          rst;
    logic [NUM_REQ-1:0]            req;
    logic [NUM_REQ*DATA_WIDTH-1:0] req_data;
    logic [NUM_REQ-1:0]            grant;
    logic [NUM_REQ-1:0]            done;
    logic                          error;
    logic                          ser_start;
    logic [DATA_WIDTH-1:0]         ser_data;
    logic                          ser_busy;
    logic                          active;
    logic [1:0]                    owner;

    int checks;
    int errors;
    int done_seen;
    logic       no_busy;
    logic [3:0] busy_cnt;

    serializer_arbiter #(
        .NUM_REQ(NUM_REQ), .DATA_WIDTH(DATA_WIDTH), .START_WAIT(START_WAIT)
    ) dut (
        .i_clock(clk), .i_reset(rst), .i_req(req), .i_req_data(req_data),
        .o_grant(grant), .o_done(done), .o_error(error), .o_ser_start(ser_start),
        .o_ser_data(ser_data), .i_ser_busy(ser_busy), .o_active(active), .o_owner(owner)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk or posedge rst) begin
        if (rst) busy_cnt <= 4'd0;
        else if (ser_start && !no_busy) busy_cnt <= 4'd8;
        else if (busy_cnt != 4'd0) busy_cnt <= busy_cnt - 4'd1;
    end
    assign ser_busy = (busy_cnt != 4'd0);

    always @(negedge clk) if (done != '0) done_seen++;

    // which: 0 = grant, 1 = done, 2 = error. cyc = negedges waited, -1 on timeout.
    task automatic wait_for(input int which, input int budget, output int cyc);
        cyc = -1;
        for (int k = 1; k <= budget; k++) begin
            @(negedge clk);
            if ((which == 0 && grant != '0) || (which == 1 && done != '0) ||
                (which == 2 && error)) begin
                cyc = k;
                return;
            end
        end
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic test_reset();
        @(negedge clk);
        checks++;
        if ({grant, done, error, ser_start, ser_data, active, owner} !== '0) begin
            $display("FAIL reset_outputs: got g=%b d=%b e=%b s=%b data=%h a=%b o=%0d required all 0",
                     grant, done, error, ser_start, ser_data, active, owner);
            errors++;
        end
        rst = 1'b0;
    endtask

    task automatic test_single();
        int cyc;
        @(negedge clk);
        req_data[7:0] = 8'h9E;
        req = 4'b0001;
        wait_for(0, 5, cyc);
        checks++;
        if (cyc !== 1 || grant !== 4'b0001 || ser_start !== 1'b1 || ser_data !== 8'h9E) begin
            $display("FAIL single_grant: got cyc=%0d g=%b s=%b data=%h required cyc=1 g=0001 s=1 data=9e",
                     cyc, grant, ser_start, ser_data);
            errors++;
        end
        req = 4'b0000;
        wait_for(1, 20, cyc);
        checks++;
        if (cyc !== 9 || done !== 4'b0001 || active !== 1'b1) begin
            $display("FAIL single_done: got cyc=%0d d=%b a=%b required cyc=9 d=0001 a=1",
                     cyc, done, active);
            errors++;
        end
        @(negedge clk);
        checks++;
        if (active !== 1'b0 || done !== 4'b0000) begin
            $display("FAIL single_idle: got a=%b d=%b required a=0 d=0000", active, done);
            errors++;
        end
    endtask

    task automatic test_round_robin();
        int cyc;
        logic [3:0] exp_g [5];
        exp_g = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0001};
        do_reset();
        req_data = {8'hA3, 8'hA2, 8'hA1, 8'hA0};
        req = 4'b1111;
        for (int n = 0; n < 5; n++) begin
            wait_for(0, 30, cyc);
            checks++;
            if (grant !== exp_g[n] || ser_data !== (8'hA0 + 8'(n % 4)) ||
                cyc !== ((n == 0) ? 1 : 11)) begin
                $display("FAIL rr_grant%0d: got g=%b data=%h cyc=%0d required g=%b data=%h cyc=%0d",
                         n, grant, ser_data, cyc, exp_g[n], 8'hA0 + 8'(n % 4), (n == 0) ? 1 : 11);
                errors++;
            end
        end
        req = 4'b0000;
        wait_for(1, 20, cyc);
        checks++;
        if (done !== 4'b0001) begin
            $display("FAIL rr_last_done: got d=%b cyc=%0d required d=0001", done, cyc);
            errors++;
        end
    endtask

    task automatic test_wrap();
        int cyc;
        @(negedge clk);
        req = 4'b0010;
        wait_for(0, 30, cyc);
        req = 4'b0000;
        checks++;
        if (grant !== 4'b0010 || owner !== 2'd1) begin
            $display("FAIL wrap_setup: got g=%b o=%0d required g=0010 o=1", grant, owner);
            errors++;
        end
        wait_for(1, 20, cyc);
        req = 4'b1010;
        wait_for(0, 30, cyc);
        checks++;
        if (grant !== 4'b1000 || owner !== 2'd3) begin
            $display("FAIL wrap_first: got g=%b o=%0d required g=1000 o=3", grant, owner);
            errors++;
        end
        wait_for(0, 30, cyc);
        req = 4'b0000;
        checks++;
        if (grant !== 4'b0010 || owner !== 2'd1) begin
            $display("FAIL wrap_second: got g=%b o=%0d required g=0010 o=1", grant, owner);
            errors++;
        end
        wait_for(1, 20, cyc);
    endtask

    task automatic test_abort();
        int cyc;
        int seen0;
        @(negedge clk);
        no_busy = 1'b1;
        req = 4'b0001;
        wait_for(0, 10, cyc);
        req = 4'b0000;
        seen0 = done_seen;
        wait_for(2, 15, cyc);
        checks++;
        if (cyc !== 1 + START_WAIT || done_seen !== seen0) begin
            $display("FAIL abort_error: got cyc=%0d dones=%0d required cyc=%0d dones=0",
                     cyc, done_seen - seen0, 1 + START_WAIT);
            errors++;
        end
        @(negedge clk);
        checks++;
        if (error !== 1'b0 || active !== 1'b0) begin
            $display("FAIL abort_pulse: got e=%b a=%b required e=0 a=0", error, active);
            errors++;
        end
        no_busy = 1'b0;
        req = 4'b0100;
        wait_for(0, 10, cyc);
        req = 4'b0000;
        checks++;
        if (cyc !== 1 || grant !== 4'b0100) begin
            $display("FAIL abort_next: got cyc=%0d g=%b required cyc=1 g=0100", cyc, grant);
            errors++;
        end
        wait_for(1, 20, cyc);
    endtask

    task automatic test_reset_mid();
        int cyc;
        int seen0;
        @(negedge clk);
        req = 4'b0010;
        wait_for(0, 10, cyc);
        req = 4'b0000;
        repeat (4) @(negedge clk);
        checks++;
        if (active !== 1'b1 || ser_busy !== 1'b1) begin
            $display("FAIL mid_in_shift: got a=%b busy=%b required a=1 busy=1", active, ser_busy);
            errors++;
        end
        rst = 1'b1;
        #1;
        checks++;
        if ({grant, done, error, ser_start, ser_data, active, owner} !== '0) begin
            $display("FAIL mid_reset_outputs: got g=%b d=%b e=%b s=%b data=%h a=%b o=%0d required all 0",
                     grant, done, error, ser_start, ser_data, active, owner);
            errors++;
        end
        repeat (2) @(negedge clk);
        rst = 1'b0;
        seen0 = done_seen;
        repeat (12) @(negedge clk);
        checks++;
        if (done_seen !== seen0) begin
            $display("FAIL mid_no_done: got %0d done pulses required 0", done_seen - seen0);
            errors++;
        end
        req = 4'b0100;
        wait_for(0, 10, cyc);
        req = 4'b0000;
        checks++;
        if (cyc !== 1 || grant !== 4'b0100 || owner !== 2'd2) begin
            $display("FAIL mid_after_grant: got cyc=%0d g=%b o=%0d required cyc=1 g=0100 o=2",
                     cyc, grant, owner);
            errors++;
        end
        wait_for(1, 20, cyc);
    endtask

    task automatic test_data_hold();
        int cyc;
        @(negedge clk);
        req_data[7:0] = 8'h55;
        req = 4'b0001;
        wait_for(0, 10, cyc);
        req = 4'b0000;
        repeat (3) @(negedge clk);
        req_data[7:0] = 8'hAA;
        wait_for(1, 20, cyc);
        checks++;
        if (done !== 4'b0001 || ser_data !== 8'h55) begin
            $display("FAIL hold_at_done: got d=%b data=%h required d=0001 data=55", done, ser_data);
            errors++;
        end
        @(negedge clk);
        checks++;
        if (ser_data !== 8'h55 || owner !== 2'd0) begin
            $display("FAIL hold_idle: got data=%h o=%0d required data=55 o=0", ser_data, owner);
            errors++;
        end
        req = 4'b0001;
        wait_for(0, 10, cyc);
        req = 4'b0000;
        checks++;
        if (grant !== 4'b0001 || ser_data !== 8'hAA) begin
            $display("FAIL hold_reselect: got g=%b data=%h required g=0001 data=aa", grant, ser_data);
            errors++;
        end
        wait_for(1, 20, cyc);
        checks++;
        if (cyc < 0) begin
            $display("FAIL hold_final_done: got timeout required done");
            errors++;
        end
    endtask

    initial begin
        checks    = 0;
        errors    = 0;
        done_seen = 0;
        no_busy   = 1'b0;
        rst       = 1'b1;
        req       = '0;
        req_data  = '0;
        test_reset();
        test_single();
        test_round_robin();
        test_wrap();
        test_abort();
        test_reset_mid();
        test_data_hold();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got no completion required finish before 200000");
        $fatal(1, "watchdog");
    end

endmodule
